// File: rtl/iommu_reg_pkg.sv
// iommu_reg_pkg: shared IOMMU register-map constants and WSI cause-state type
package iommu_reg_pkg;
  localparam int CAUSE_CIP     = 0;
  localparam int CAUSE_FIP     = 1;
  localparam int CAUSE_PMIP    = 2;
  localparam int CAUSE_PIP     = 3;
  localparam int N_IPSR_CAUSES = 4;
  typedef enum logic [1:0] {WSI_IDLE, WSI_SET, WSI_ACTIVE} wsi_cause_state_e;
  function automatic int vec_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/iommu_wsi_cause_fsm.sv
// iommu_wsi_cause_fsm: rising-edge detect and ipsr set-request FSM for one interrupt cause
module iommu_wsi_cause_fsm
  import iommu_reg_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cond_i,
  input  logic ipsr_i,
  output logic set_o
);
  wsi_cause_state_e state_q, state_d;
  logic cond_q, armed_q, evt;
  // armed_q masks the first sampled cycle so a level already high at reset release is not an edge
  assign evt = cond_i & ~cond_q & armed_q;
  assign set_o = state_q == WSI_SET;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WSI_IDLE;
      cond_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_i;
      armed_q <= 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WSI_IDLE:   state_d = (evt & ~ipsr_i) ? WSI_SET : (evt | ipsr_i) ? WSI_ACTIVE : WSI_IDLE;
      WSI_SET:    state_d = ipsr_i ? WSI_ACTIVE : WSI_SET;
      WSI_ACTIVE: state_d = ipsr_i ? WSI_ACTIVE : evt ? WSI_SET : WSI_IDLE;
      default:    state_d = WSI_IDLE;
    endcase
  end
endmodule

// File: rtl/iommu_wsi_ig.sv
// iommu_wsi_ig: turns CQ/FQ/HPM/PQ events into ipsr set requests and drives icvec-mapped WSI wires
module iommu_wsi_ig
  import iommu_reg_pkg::*;
#(
  parameter int N_INT_VEC = 16,
  parameter int N_CAUSES  = N_IPSR_CAUSES,
  parameter int VEC_W     = vec_w(N_INT_VEC)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wsi_en_i,
  input  logic                  cq_evt_i,
  input  logic                  cie_i,
  input  logic                  fq_evt_i,
  input  logic                  fie_i,
  input  logic                  pm_evt_i,
  input  logic                  pq_evt_i,
  input  logic [N_CAUSES-1:0]   ipsr_q_i,
  input  logic [4*N_CAUSES-1:0] icvec_i,
  output logic [N_CAUSES-1:0]   ipsr_set_o,
  output logic [N_INT_VEC-1:0]  wsi_o
);
  logic [N_CAUSES-1:0] cond;
  logic [N_INT_VEC-1:0] wsi_d;
  assign cond = {pq_evt_i, pm_evt_i, fq_evt_i & fie_i, cq_evt_i & cie_i};
  for (genvar c = 0; c < N_CAUSES; c++) begin : g_cause
    iommu_wsi_cause_fsm u_fsm (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .cond_i (cond[c]),
      .ipsr_i (ipsr_q_i[c]),
      .set_o  (ipsr_set_o[c])
    );
  end
  // only the low VEC_W bits of each icvec field select a wire; the rest are WARL in the regmap
  always_comb begin
    wsi_d = '0;
    for (int v = 0; v < N_INT_VEC; v++)
      for (int i = 0; i < N_CAUSES; i++)
        wsi_d[v] = wsi_d[v] | (ipsr_q_i[i] & (icvec_i[4*i +: VEC_W] == VEC_W'(v)));
    wsi_d = wsi_en_i ? wsi_d : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wsi_o <= '0;
    else wsi_o <= wsi_d;
  end
endmodule

// File: tb/tb_iommu_wsi_ig.sv
// tb_iommu_wsi_ig: directed and randomized checks of iommu_wsi_ig against a behavioural model with a regmap ipsr emulation
module tb_iommu_wsi_ig;
  localparam int N = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wsi_en = 0, cq = 0, cie = 0, fq = 0, fie = 0, pm = 0, pq = 0;
  logic [3:0] ipsr_q = '0, ipsr_nxt = '0, w1c = '0, sws = '0, set, prev_set = '0;
  logic [15:0] icvec = '0, wsi;
  logic [3:0] m_owed, m_cprev;
  logic m_armed;
  logic [15:0] m_wsi;
  int tests = 0, fails = 0, set_rise1 = 0, base;

  always #5 clk = ~clk;

  iommu_wsi_ig #(.N_INT_VEC(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wsi_en_i(wsi_en),
    .cq_evt_i(cq), .cie_i(cie), .fq_evt_i(fq), .fie_i(fie),
    .pm_evt_i(pm), .pq_evt_i(pq), .ipsr_q_i(ipsr_q), .icvec_i(icvec),
    .ipsr_set_o(set), .wsi_o(wsi)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cond_now();
    return {pq, pm, fq & fie, cq & cie};
  endfunction

  // a set request is owed from an accepted edge until the pending bit reads back as 1
  function automatic logic [3:0] owed_next(input logic [3:0] owed, input logic [3:0] cnd,
                                           input logic [3:0] prev, input logic armed, input logic [3:0] ip);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = ~ip[c] & (owed[c] | (cnd[c] & ~prev[c] & armed));
    return r;
  endfunction

  function automatic logic [15:0] wsi_of(input logic en, input logic [3:0] ip, input logic [15:0] iv);
    logic [15:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) if (en && ip[c]) r[((iv >> (4 * c)) & 16'hf) % N] = 1'b1;
    return r;
  endfunction

  // regmap ipsr: hw set wins over a same-cycle W1C
  always @(negedge clk) ipsr_nxt <= (ipsr_q & ~w1c) | set | sws;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ipsr_q <= '0;
    else ipsr_q <= ipsr_nxt;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_owed <= '0; m_cprev <= '0; m_armed <= 1'b0; m_wsi <= '0;
    end else begin
      m_owed  <= owed_next(m_owed, cond_now(), m_cprev, m_armed, ipsr_q);
      m_cprev <= cond_now();
      m_armed <= 1'b1;
      m_wsi   <= wsi_of(wsi_en, ipsr_q, icvec);
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("model_set", {12'd0, set}, {12'd0, m_owed});
      chk("model_wsi", wsi, m_wsi);
      if (set[1] && !prev_set[1]) set_rise1 <= set_rise1 + 1;
      prev_set <= set;
    end

  initial begin
    {cq, fq, pm, pq, cie, fie} = '1;
    step(3);
    chk("rst_wsi", wsi, 16'h0);
    chk("rst_set", {12'd0, set}, 16'h0);
    rst_n = 1'b1;
    step(4);
    chk("rel_held_no_evt", {12'd0, set}, 16'h0);
    {cq, fq, pm, pq} = '0;
    step(2);
    icvec = 16'h0005; wsi_en = 1; cq = 1;
    step(1);
    chk("cq_set_t1", {12'd0, set}, 16'h0001);
    cq = 0;
    step(1);
    chk("cq_set_held", {12'd0, set}, 16'h0001);
    step(1);
    chk("cq_wsi", wsi, 16'h0020);
    chk("cq_set_drop", {12'd0, set}, 16'h0);
    w1c = 4'h1; step(1); w1c = 0; step(1);
    chk("cq_clear", wsi, 16'h0);
    fie = 0; fq = 1; step(2); fq = 0;
    chk("fq_gated", {12'd0, set}, 16'h0);
    step(1);
    sws = 4'h2; step(1); sws = 0;
    wsi_en = 0; icvec = 16'h0075;
    step(2);
    chk("en_off", wsi, 16'h0);
    chk("sw_set_no_req", {12'd0, set}, 16'h0);
    wsi_en = 1; step(1);
    chk("en_on", wsi, 16'h0080);
    icvec = 16'h0033; sws = 4'h1; step(1); sws = 0; step(1);
    chk("shared_both", wsi, 16'h0008);
    w1c = 4'h1; step(1); w1c = 0; step(1);
    chk("shared_cip_clr", wsi, 16'h0008);
    w1c = 4'h2; step(1); w1c = 0; step(1);
    chk("shared_fip_clr", wsi, 16'h0);
    icvec = 16'h0633; pm = 1; step(1);
    chk("race_set", {12'd0, set}, 16'h0004);
    w1c = 4'h4; step(1); w1c = 0; pm = 0; step(2);
    chk("race_ipsr", {12'd0, ipsr_q}, 16'h0004);
    chk("race_wsi", wsi, 16'h0040);
    chk("race_active", {12'd0, set}, 16'h0);
    fie = 1; sws = 4'h2; step(1); sws = 0; step(2);
    base = set_rise1;
    repeat (5) begin fq = 1; step(1); fq = 0; step(1); end
    chk("coalesce", 16'(set_rise1 - base), 16'h0);
    chk("coal_pend", {12'd0, ipsr_q}, 16'h0006);
    icvec = 16'h0623; step(1);
    chk("remap_a", wsi, 16'h0044);
    icvec = 16'h0693; step(1);
    chk("remap_b", wsi, 16'h0240);
    w1c = 4'hf; step(1); w1c = 0; step(1);
    for (int i = 0; i < 3000; i++) begin
      cq = $urandom_range(0, 3) == 0; fq = $urandom_range(0, 3) == 0;
      pm = $urandom_range(0, 3) == 0; pq = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 15) == 0) begin cie = 1'($urandom); fie = 1'($urandom); end
      if ($urandom_range(0, 15) == 0) icvec = 16'($urandom);
      wsi_en = $urandom_range(0, 7) != 0;
      w1c = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      sws = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
      if (i == 1500) begin
        rst_n = 0; #2;
        chk("mid_rst_wsi", wsi, 16'h0);
        chk("mid_rst_set", {12'd0, set}, 16'h0);
        rst_n = 1;
      end
      step(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
